// File: rtl/concat_packer.sv
// Bit-level packer: appends variable-length LSB-aligned fragments into an
// accumulator and emits fixed-width words, with flush and partial-word padding.
module concat_packer #(
    parameter  int IN_W     = 50,
    parameter  int OUT_W    = 72,
    parameter  int SIGN_PAD = 0,
    localparam int LEN_W    = $clog2(IN_W + 1),
    localparam int CNT_W    = $clog2(OUT_W + IN_W + 1),
    localparam int OB_W     = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [OB_W-1:0]  out_bits,
    output logic             out_last,
    output logic [CNT_W-1:0] fill_level
);

    localparam int ACC_W = OUT_W + IN_W;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             flush_q, flush_d;

    logic [LEN_W-1:0] eff_len;
    logic [IN_W-1:0]  data_m;
    logic [OB_W-1:0]  bits_c;
    logic [OUT_W-1:0] raw;
    logic             sign_bit;
    logic             in_fire, out_fire, last_c, valid_c, ready_c;

    always_comb begin
        eff_len = (in_len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : in_len;
        data_m  = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (i < 32'(eff_len)) data_m[i] = in_data[i];
        end
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        ready_c  = rst_n && (fill_q < CNT_W'(OUT_W)) && !flush_q;
        valid_c  = (fill_q >= CNT_W'(OUT_W)) || flush_q;
        last_c   = flush_q && (fill_q <= CNT_W'(OUT_W));
        in_fire  = in_valid && ready_c;
        out_fire = valid_c && out_ready;
    end

    always_comb begin
        if (fill_q >= CNT_W'(OUT_W)) bits_c = OB_W'(OUT_W);
        else                         bits_c = OB_W'(fill_q);
        raw      = acc_q[OUT_W-1:0];
        sign_bit = 1'b0;
        if ((SIGN_PAD != 0) && (bits_c != '0)) sign_bit = raw[bits_c - OB_W'(1)];
        out_data = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (i < 32'(bits_c)) out_data[i] = raw[i];
            else                 out_data[i] = sign_bit;
        end
    end

    always_comb begin
        acc_d   = acc_q;
        fill_d  = fill_q;
        flush_d = flush_q;
        if (in_fire) begin
            acc_d  = acc_q | (ACC_W'(data_m) << fill_q);
            fill_d = fill_q + CNT_W'(eff_len);
            if (in_last) flush_d = 1'b1;
        end else if (out_fire) begin
            acc_d  = acc_q >> OUT_W;
            fill_d = fill_q - CNT_W'(bits_c);
            if (last_c) flush_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            fill_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            flush_q <= flush_d;
        end
    end

    assign in_ready   = ready_c;
    assign out_valid  = valid_c;
    assign out_bits   = bits_c;
    assign out_last   = last_c;
    assign fill_level = fill_q;

endmodule
